// File: rtl/mu0x_pkg.sv
// Shared opcodes, FSM states and ALU operation encodings for the mu0x core.
package mu0x_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPC_W-1:0] OP_STO = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h4;
  localparam logic [OPC_W-1:0] OP_JGE = 4'h5;
  localparam logic [OPC_W-1:0] OP_JNE = 4'h6;
  localparam logic [OPC_W-1:0] OP_STP = 4'h7;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h8;
  localparam logic [OPC_W-1:0] OP_AND = 4'h9;
  localparam logic [OPC_W-1:0] OP_OR  = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } stateT;

  typedef enum logic [2:0] {
    ALU_PASS_B,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } aluOpT;

  // ALU operation used in the MEM state for a given opcode (loads and stores pass memory data).
  function automatic aluOpT aluOpFor(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_PASS_B;
    endcase
  endfunction

endpackage

// File: rtl/mu0x_alu.sv
// Combinational accumulator ALU; a is the accumulator, b is memory read data.
module mu0x_alu
  import mu0x_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  aluOpT             op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] resultC
);

  // Select the result; arithmetic wraps modulo 2^DATA_W with no flags.
  always_comb begin
    resultC = b;
    case (op)
      ALU_PASS_B: resultC = b;
      ALU_ADD:    resultC = a + b;
      ALU_SUB:    resultC = a - b;
      ALU_AND:    resultC = a & b;
      ALU_OR:     resultC = a | b;
      default:    resultC = b;
    endcase
  end

endmodule

// File: rtl/mu0x_core.sv
// Multi-cycle MU0-family core: width-generic datapath, req/ack memory port,
// extended opcodes and illegal-opcode trapping.
module mu0x_core
  import mu0x_pkg::*;
#(
  parameter  int unsigned DATA_W   = 16,
  localparam int unsigned ADDR_W   = DATA_W - 4,
  parameter  int unsigned START_PC = 0,
  parameter  int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] ir,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_PC);

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] pcNext;
  logic [DATA_W-1:0] accNext;
  logic [DATA_W-1:0] irNext;
  logic [CNT_W-1:0]  retiredNext;
  logic              doneNext;
  logic              illegalNext;
  logic              busyNext;
  logic              memReqNext;
  logic              memWeNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic              toFetch;

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] aluY;

  assign opcode    = ir[DATA_W-1 -: OPC_W];
  assign operand   = ir[ADDR_W-1:0];
  assign mem_wdata = acc;

  mu0x_alu #(
    .DATA_W (DATA_W)
  ) uAlu (
    .op      (aluOpFor(opcode)),
    .a       (acc),
    .b       (mem_rdata),
    .resultC (aluY)
  );

  // Next-state and next-register decode for every state.
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    accNext     = acc;
    irNext      = ir;
    retiredNext = retired;
    doneNext    = done;
    illegalNext = illegal;
    memReqNext  = mem_req;
    memWeNext   = mem_we;
    memAddrNext = mem_addr;
    toFetch     = 1'b0;

    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pcNext      = START_ADDR;
          accNext     = '0;
          retiredNext = '0;
          doneNext    = 1'b0;
          illegalNext = 1'b0;
          stateNext   = ST_FETCH;
          memReqNext  = 1'b1;
          memWeNext   = 1'b0;
          memAddrNext = START_ADDR;
        end
      end

      ST_FETCH: begin
        if (mem_ack) begin
          irNext     = mem_rdata;
          pcNext     = pc + ADDR_W'(1);
          stateNext  = ST_EXEC;
          memReqNext = 1'b0;
        end
      end

      ST_EXEC: begin
        case (opcode)
          OP_LDA, OP_STO, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            stateNext   = ST_MEM;
            memReqNext  = 1'b1;
            memWeNext   = (opcode == OP_STO);
            memAddrNext = operand;
          end
          OP_JMP: begin
            pcNext  = operand;
            toFetch = 1'b1;
          end
          OP_JGE: begin
            if (!acc[DATA_W-1]) pcNext = operand;
            toFetch = 1'b1;
          end
          OP_JNE: begin
            if (acc != '0) pcNext = operand;
            toFetch = 1'b1;
          end
          OP_LDI: begin
            accNext = DATA_W'(operand);
            toFetch = 1'b1;
          end
          OP_STP: begin
            stateNext   = ST_HALT;
            doneNext    = 1'b1;
            retiredNext = retired + CNT_W'(1);
          end
          default: begin
            stateNext   = ST_HALT;
            doneNext    = 1'b1;
            illegalNext = 1'b1;
          end
        endcase
      end

      ST_MEM: begin
        if (mem_ack) begin
          if (opcode != OP_STO) accNext = aluY;
          toFetch = 1'b1;
        end
      end

      default: begin
        stateNext  = ST_IDLE;
        memReqNext = 1'b0;
        memWeNext  = 1'b0;
      end
    endcase

    // Retire the instruction and issue the next fetch from the updated PC.
    if (toFetch) begin
      stateNext   = ST_FETCH;
      memReqNext  = 1'b1;
      memWeNext   = 1'b0;
      memAddrNext = pcNext;
      retiredNext = retired + CNT_W'(1);
    end

    busyNext = (stateNext == ST_FETCH) || (stateNext == ST_EXEC) || (stateNext == ST_MEM);
  end

  // State and architectural registers; memory port outputs are flops only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      acc      <= '0;
      ir       <= '0;
      retired  <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      acc      <= accNext;
      ir       <= irNext;
      retired  <= retiredNext;
      done     <= doneNext;
      illegal  <= illegalNext;
      busy     <= busyNext;
      mem_req  <= memReqNext;
      mem_we   <= memWeNext;
      mem_addr <= memAddrNext;
    end
  end

endmodule

// File: doc/mu0x_core.md
# mu0x_core

Parametrised, multi-cycle MU0-family processor core with a width-generic datapath, a req/ack memory port that tolerates variable-latency memory, an extended opcode set, and illegal-opcode trapping. It replaces the fixed 16-bit MU0 core between the simulator's memory model and the host/debug logic. The host loads memory directly, pulses `start`, and watches `done`/`illegal`.

## Interface
- `DATA_W`, 16: data, accumulator and instruction width; must be ≥ 8.
- `ADDR_W`, `DATA_W-4` (derived, not overridable): operand/address width; `ir[DATA_W-1 -: 4]` is the opcode, `ir[ADDR_W-1:0]` the operand.
- `START_PC`, 0: PC loaded on `start`.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse. Honoured only in IDLE or HALT.
- `mem_req` out 1: memory request, held until acked.
- `mem_we` out 1: 1 = write, 0 = read. Valid while `mem_req`.
- `mem_addr` out ADDR_W: address. Valid while `mem_req`.
- `mem_wdata` out DATA_W: write data (= `acc`). Valid while `mem_req && mem_we`.
- `mem_rdata` in DATA_W: read data, sampled in the ack cycle.
- `mem_ack` in 1: completes the transfer in any cycle where `mem_req` is high.
- `busy` out 1: high in FETCH/EXEC/MEM.
- `done` out 1: level, high in HALT.
- `illegal` out 1: level, set with `done` on an illegal opcode; cleared by `start`/`reset`.
- `pc` out ADDR_W, `acc` out DATA_W, `ir` out DATA_W: architectural state, for debug.
- `retired` out CNT_W: number of instructions completed since the last `start`.

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALT.
- `reset`: state IDLE. `pc`, `acc`, `ir`, `retired`, `done`, `illegal`, `mem_req`, `mem_we` all 0.
- IDLE/HALT + `start`: `pc<=START_PC`, `acc<=0`, `retired<=0`, `done/illegal<=0`, go to FETCH.
- FETCH: `mem_req=1`, `mem_we=0`, `mem_addr=pc`. On ack: `ir<=mem_rdata`, `pc<=pc+1` (wraps mod 2^ADDR_W), go to EXEC.
- EXEC, decode by opcode (S = operand):
  - 0 LDA, 2 ADD, 3 SUB, 9 AND, A OR, 1 STO: go to MEM.
  - 4 JMP: `pc<=S`.
  - 5 JGE: `pc<=S` if `acc[DATA_W-1]==0`.
  - 6 JNE: `pc<=S` if `acc!=0`.
  - 8 LDI: `acc<=zero-extend(S)`.
  - 7 STP: go to HALT.
  - B–F: set `illegal`, go to HALT.
  - Non-memory legal ops then go to FETCH. A not-taken jump leaves `pc` unchanged.
- MEM: `mem_req=1`, `mem_addr=S`, `mem_we=(op==STO)`. On ack:
  - LDA: `acc<=rdata`.
  - ADD: `acc<=acc+rdata`.
  - SUB: `acc<=acc-rdata`.
  - AND: `acc<=acc&rdata`.
  - OR: `acc<=acc|rdata`.
  - STO: memory writes `acc`.
  - Then go to FETCH.
- Arithmetic is modulo 2^DATA_W, with no flags.
- `retired` increments (wrapping) on completion of every legal instruction, including STP. It does not increment on an illegal opcode.
- `start` outside IDLE/HALT is ignored.

## Timing
- `mem_*` outputs are driven from registered state only (no combinational path from `mem_ack` or `mem_rdata`). They stay stable while `mem_req` is high and unacked.
- Ack may arrive in the same cycle `mem_req` rises, giving zero-wait operation.
- With zero-wait memory:
  - Jump/LDI: 2 cycles (FETCH, EXEC).
  - Memory op: 3 cycles.
  - Each wait cycle adds 1.
- `mem_req` drops in the cycle after the ack. A new request (next FETCH) may rise in that same cycle after EXEC, so there is no back-to-back conflict.
- `done` rises the cycle after EXEC of STP or an illegal opcode.
- `reset` mid-transaction: `mem_req` is low the next cycle. The memory must discard the pending access; an STO aborted before ack is not committed.
- `reset` has priority over `start` in the same cycle.

## Structure
- Package `mu0x_pkg`: opcode localparams (OP_LDA…OP_OR), state enum, and ALU-op enum (PASS_B, ADD, SUB, AND, OR).
- One sub-module, `mu0x_alu` (combinational, parametrised by DATA_W), selected in MEM. The FSM and registers live in `mu0x_core`.

## Test plan
- Zero-wait memory, DATA_W=16. Program `LDA 10; ADD 11; STO 12; STP` with mem[10]=0x0005, mem[11]=0x0003 -> mem[12]=0x0008, `done=1`, `retired=4`, total 3+3+3+2=11 cycles from FETCH entry.
- Random 0–3 wait cycles on every ack, same program -> identical result. `mem_addr`/`mem_we`/`mem_wdata` stable throughout each wait.
- Loop `LDI 3; SUB one; JNE 1; STP` with mem[one]=1 -> `acc=0`, `retired=1+3×2+1=8`, `pc` ends at 4.
- Opcode 0xC at address 0 -> `done=1`, `illegal=1`, `retired=0`. A subsequent `start` clears both and refetches from START_PC.
- DATA_W=24: `LDI 0xFFFFF` then ADD of 0x000001 -> `acc=0x100000`. SUB from 0 yields 0xFFFFFF, and JGE is not taken.
- Assert `reset` during a waited STO MEM cycle -> `mem_req=0` next cycle, no write committed, state IDLE, all outputs 0.
